data_memory_pl: RTL
===================

# data_memory_pl

Parametrised, pipelined data memory for the core's load/store unit. It replaces the flat word-only data memory. It adds RISC-V byte/halfword/word accesses with sign or zero extension, byte-lane writes, and a valid/ready request port. Responses come back on a fixed-latency response port. Misaligned, out-of-range and illegal accesses are reported as faults. A sequential zero-fill runs after every reset.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words (power of two, ≥4)
- READ_LATENCY, 1, cycles from request acceptance to response (1..4)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 access size/sign
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result, extended; 0 for stores and faults
- resp_fault  out  1  request was rejected (no memory side effect)

## Operation
- FSM states: INIT and RUN.
- Reset asserted: state forced to INIT; init index forced to 0; all pipeline valid bits cleared.
- INIT:
  - writes 0 to word[init index] each cycle, then increments the index;
  - after DEPTH_WORDS cycles (index DEPTH_WORDS-1 written), moves to RUN;
  - req_ready = 0 throughout.
- RUN: req_ready = 1. Accept = req_valid & req_ready. At most one request per cycle, no back-pressure on responses.
- Word index = req_addr[31:2]. Byte offset = req_addr[1:0].
- Fault if any of the following:
  - word index ≥ DEPTH_WORDS;
  - funct3 ∉ {000, 001, 010, 100, 101} for loads;
  - funct3 ∉ {000, 001, 010} for stores;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0.
- Stores (no fault), committed at the accept edge:
  - SB writes lane addr[1:0] with wdata[7:0];
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - SW writes all lanes.
  - Unselected lanes are unchanged.
- Loads (no fault):
  - the addressed word is captured at the accept edge;
  - the selected byte/half is shifted to bit 0;
  - 000/001 sign-extend, 100/101 zero-extend, 010 passes the word through.
- Every accepted request produces exactly one response, carried through a READ_LATENCY-deep pipeline of {valid, rdata, fault}.
- Faulted request: no write, resp_rdata = 0, resp_fault = 1.
- Requests with req_valid = 1 while req_ready = 0 are ignored: no response, no side effect.

## Timing
- Reset values: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_fault = 0.
- After reset deasserts, req_ready rises in cycle DEPTH_WORDS (first RUN cycle).
- Response latency: request accepted in cycle N gives resp_valid = 1 in cycle N+READ_LATENCY, for exactly one cycle.
- resp_rdata and resp_fault are valid only with resp_valid. They are 0 whenever resp_valid = 0.
- Full throughput: back-to-back requests give back-to-back responses in order.
- Read-after-write: a store accepted in cycle N is visible to a load accepted in cycle N+1.
- Reset mid-operation (async):
  - in-flight responses are discarded immediately and outputs go to their reset values;
  - a store not yet at its accept edge is lost;
  - the full INIT sweep repeats.

## Test plan
- Reset, then count cycles: req_ready = 0 for exactly DEPTH_WORDS cycles. Then LW from 0x0, 0x3FC → rdata 0x00000000, fault 0.
- SW 0x80 = 0x8899AABB; then LB 0x81 → 0xFFFFFFAA, LBU 0x81 → 0x000000AA, LH 0x82 → 0xFFFF8899, LHU 0x80 → 0x0000AABB. Each response arrives READ_LATENCY cycles after accept, for READ_LATENCY = 1 and 3.
- SW 0x40 = 0x11223344, SB 0x42 = 0x..EE, SH 0x40 = 0x..5566, then LW 0x40 → 0x11EE5566.
- Faults, each giving resp_fault = 1 and rdata 0 with memory unchanged:
  - LH 0x41, LW 0x42, SW 0x400 (DEPTH_WORDS = 256);
  - load funct3 011;
  - store funct3 100.
  - A subsequent LW 0x40 returns the prior value.
- Back-to-back: 8 consecutive accepted requests (mixed SW/LW to the same address, alternating) → 8 consecutive resp_valid cycles, in order, each load returning the immediately preceding store's data.
- Assert reset with 2 loads in flight: resp_valid drops immediately, no stale response appears, INIT repeats, and the earlier-stored word reads 0.

Source files
------------

// File: rtl/data_memory_pl.sv
// Pipelined RISC-V load/store data memory: byte/half/word access, lane writes,
// fixed-latency responses, fault reporting and a zero-fill sweep after reset.
module data_memory_pl #(
   parameter int unsigned DEPTH_WORDS  = 256,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q;
   logic [AW-1:0]   init_idx_q;
   logic            ready_q;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [READ_LATENCY-1:0] valid_q;
   logic [READ_LATENCY-1:0] fault_q;
   logic [31:0]             rdata_q [READ_LATENCY];

   logic          accept;
   logic [AW-1:0] widx;
   logic [1:0]    boff;
   logic          fault;
   logic [3:0]    be;
   logic [31:0]   wlanes;
   logic [31:0]   shifted;
   logic [31:0]   load_data;
   logic          do_write;
   logic          valid_d;
   logic          fault_d;
   logic [31:0]   rdata_d;

   always_comb begin
      accept  = req_valid & ready_q;
      widx    = req_addr[AW+1:2];
      boff    = req_addr[1:0];
      fault   = (req_addr[31:2] >= 30'(DEPTH_WORDS));
      be      = '0;
      wlanes  = '0;
      // Store data is replicated across lanes so the enable mask alone picks the target bytes.
      case (req_funct3)
         3'b000: begin
            be     = 4'b0001 << boff;
            wlanes = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            be     = boff[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{req_wdata[15:0]}};
            if (boff[0]) fault = 1'b1;
         end
         3'b010: begin
            be     = 4'b1111;
            wlanes = req_wdata;
            if (boff != 2'b00) fault = 1'b1;
         end
         3'b100: if (req_write) fault = 1'b1;
         3'b101: if (req_write || boff[0]) fault = 1'b1;
         default: fault = 1'b1;
      endcase

      shifted = mem_q[widx] >> {boff, 3'b000};
      case (req_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase

      do_write = accept & req_write & ~fault;
      valid_d  = accept;
      fault_d  = accept & fault;
      rdata_d  = (accept & ~fault & ~req_write) ? load_data : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= INIT;
         init_idx_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               init_idx_q <= init_idx_q + 1'b1;
               if (init_idx_q == AW'(DEPTH_WORDS - 1)) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[init_idx_q] <= '0;
      end else if (do_write) begin
         for (int unsigned l = 0; l < 4; l++) begin
            if (be[l]) mem_q[widx][8*l +: 8] <= wlanes[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         fault_q <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) rdata_q[i] <= '0;
      end else begin
         valid_q[0] <= valid_d;
         fault_q[0] <= fault_d;
         rdata_q[0] <= rdata_d;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            fault_q[i] <= fault_q[i-1];
            rdata_q[i] <= rdata_q[i-1];
         end
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q[READ_LATENCY-1];
   assign resp_fault = fault_q[READ_LATENCY-1];
   assign resp_rdata = rdata_q[READ_LATENCY-1];

endmodule
